// File: rtl/cross_bar_rr_arbiter_if.sv
// cross_bar_rr_arbiter_if: request/ack/grant bundle between one crossbar slave port and its arbiter.
// timeout_err exists only when CB_ARB_TIMEOUT_EN is defined.
interface cross_bar_rr_arbiter_if #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W = $clog2(N_MASTERS)
);
  logic [N_MASTERS-1:0] req;
  logic slave_ack;
  logic [N_MASTERS-1:0] grant;
  logic [IDX_W-1:0] grant_idx;
  logic grant_valid;
`ifdef CB_ARB_TIMEOUT_EN
  logic timeout_err;
  modport master (output req, slave_ack, input grant, grant_idx, grant_valid, timeout_err);
  modport slave (input req, slave_ack, output grant, grant_idx, grant_valid, timeout_err);
`else
  modport master (output req, slave_ack, input grant, grant_idx, grant_valid);
  modport slave (input req, slave_ack, output grant, grant_idx, grant_valid);
`endif
endinterface

// File: rtl/cross_bar_rr_arbiter.sv
// cross_bar_rr_arbiter: per-slave round-robin arbiter holding a one-hot grant until ack or abort.
// Optional forced release after TIMEOUT_CYCLES without ack when CB_ARB_TIMEOUT_EN is defined.
module cross_bar_rr_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int IDX_W = $clog2(N_MASTERS),
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic clk,
  input logic rst,
  cross_bar_rr_arbiter_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d, ptr_q, ptr_d, win_nxt, arb_ptr, pick;
  logic [N_MASTERS-1:0] mreq;
  logic found, tmo;
`ifdef CB_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d;
  assign tmo = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
`else
  assign tmo = 1'b0;
`endif
  assign win_nxt = (win_q == IDX_W'(N_MASTERS - 1)) ? '0 : win_q + 1'b1;
  // In GRANT the search is a completion re-arbitration: winner masked, pointer already advanced.
  assign arb_ptr = (state_q == GRANT) ? win_nxt : ptr_q;
  assign mreq = (state_q == GRANT) ? bus.req & ~(N_MASTERS'(1) << win_q) : bus.req;
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int i = N_MASTERS - 1; i >= 0; i--)
      if (mreq[(int'(arb_ptr) + i) % N_MASTERS]) begin
        found = 1'b1;
        pick = IDX_W'((int'(arb_ptr) + i) % N_MASTERS);
      end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      win_q <= '0;
      ptr_q <= '0;
`ifdef CB_ARB_TIMEOUT_EN
      cnt_q <= '0;
      to_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      ptr_q <= ptr_d;
`ifdef CB_ARB_TIMEOUT_EN
      cnt_q <= cnt_d;
      to_q <= to_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    ptr_d = ptr_q;
`ifdef CB_ARB_TIMEOUT_EN
    cnt_d = (state_q == GRANT && !bus.slave_ack) ? cnt_q + 1'b1 : '0;
    to_d = 1'b0;
`endif
    if (state_q == IDLE) begin
      state_d = found ? GRANT : IDLE;
      win_d = found ? pick : win_q;
    end else if (bus.slave_ack) begin
      ptr_d = win_nxt;
      state_d = found ? GRANT : IDLE;
      win_d = found ? pick : win_q;
    end else if (!bus.req[win_q] || tmo) begin
      ptr_d = win_nxt;
      state_d = IDLE;
`ifdef CB_ARB_TIMEOUT_EN
      to_d = tmo;
`endif
    end
  end
  always_comb begin
    bus.grant = (state_q == GRANT) ? N_MASTERS'(1) << win_q : '0;
    bus.grant_idx = (state_q == GRANT) ? win_q : '0;
    bus.grant_valid = state_q == GRANT;
`ifdef CB_ARB_TIMEOUT_EN
    bus.timeout_err = to_q;
`endif
  end
endmodule

// File: tb/tb_cross_bar_rr_arbiter.sv
// tb_cross_bar_rr_arbiter: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_cross_bar_rr_arbiter;
  localparam int N = 4;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  cross_bar_rr_arbiter_if #(.N_MASTERS(N)) bus ();
  cross_bar_rr_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {logic [3:0] g; logic te; int id;} exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, sid = 0;
  task automatic step(input logic r, input logic [3:0] rq, input logic a, input logic [3:0] g, input logic te = 1'b0);
    rst = r;
    bus.req = rq;
    bus.slave_ack = a;
    @(posedge clk);
    q.push_back('{g, te, sid});
    sid++;
    #2;
  endtask
  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask
  always @(negedge clk)
    while (q.size() > 0) begin
      exp_t e;
      logic [1:0] ei;
      e = q.pop_front();
      ei = 2'd0;
      for (int k = 0; k < N; k++) if (e.g[k]) ei = 2'(k);
      chk("grant", e.id, 32'(bus.grant), 32'(e.g));
      chk("grant_idx", e.id, 32'(bus.grant_idx), 32'(ei));
      chk("grant_valid", e.id, 32'(bus.grant_valid), 32'(|e.g));
`ifdef CB_ARB_TIMEOUT_EN
      chk("timeout_err", e.id, 32'(bus.timeout_err), 32'(e.te));
`endif
    end
  initial begin
    rst = 1'b1;
    bus.req = '0;
    bus.slave_ack = 1'b0;
    // reset holds grant low despite requests
    step(1, 4'b1111, 0, 4'b0000);
    step(1, 4'b1111, 0, 4'b0000);
    // full rotation, ack on every second grant cycle
    step(0, 4'b1111, 0, 4'b0001);
    step(0, 4'b1111, 0, 4'b0001);
    step(0, 4'b1111, 1, 4'b0010);
    step(0, 4'b1111, 0, 4'b0010);
    step(0, 4'b1111, 1, 4'b0100);
    step(0, 4'b1111, 0, 4'b0100);
    step(0, 4'b1111, 1, 4'b1000);
    step(0, 4'b1111, 0, 4'b1000);
    step(0, 4'b1111, 1, 4'b0001);
    step(0, 4'b1111, 0, 4'b0001);
    step(0, 4'b1111, 1, 4'b0010);
    step(0, 4'b0000, 1, 4'b0000);
    // two-master contention from ptr=0
    step(1, 4'b0000, 0, 4'b0000);
    step(0, 4'b1010, 0, 4'b0010);
    step(0, 4'b1010, 0, 4'b0010);
    step(0, 4'b1010, 0, 4'b0010);
    step(0, 4'b1010, 1, 4'b1000);
    step(0, 4'b1000, 0, 4'b1000);
    step(0, 4'b1000, 0, 4'b1000);
    step(0, 4'b1000, 1, 4'b0000);
    step(0, 4'b1001, 0, 4'b0001);
    step(0, 4'b1000, 0, 4'b0000);
    // sole requester needs one idle cycle; ack in IDLE is ignored
    step(0, 4'b0100, 0, 4'b0100);
    step(0, 4'b0100, 1, 4'b0000);
    step(0, 4'b0100, 0, 4'b0100);
    step(0, 4'b0100, 1, 4'b0000);
    step(0, 4'b0000, 1, 4'b0000);
    step(0, 4'b0101, 0, 4'b0001);
    // abort of master 2 leaves ptr=3, then reset mid-grant
    step(0, 4'b0000, 0, 4'b0000);
    step(0, 4'b0100, 0, 4'b0100);
    step(0, 4'b0000, 0, 4'b0000);
    step(0, 4'b1001, 0, 4'b1000);
    step(1, 4'b1001, 0, 4'b0000);
    step(0, 4'b1001, 0, 4'b0001);
    step(0, 4'b0000, 1, 4'b0000);
`ifdef CB_ARB_TIMEOUT_EN
    step(1, 4'b0000, 0, 4'b0000);
    step(0, 4'b0001, 0, 4'b0001);
    for (int i = 0; i < 15; i++) step(0, 4'b0001, 0, 4'b0001);
    step(0, 4'b0001, 0, 4'b0000, 1'b1);
    step(0, 4'b0011, 0, 4'b0010);
    step(0, 4'b0000, 1, 4'b0000);
    step(1, 4'b0000, 0, 4'b0000);
    step(0, 4'b0001, 0, 4'b0001);
    for (int i = 0; i < 15; i++) step(0, 4'b0001, 0, 4'b0001);
    step(0, 4'b0001, 1, 4'b0000);
    step(0, 4'b0000, 0, 4'b0000);
`endif
    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cross_bar_rr_arbiter.md
Name: cross_bar_rr_arbiter

Overview:
- Per-slave round-robin arbiter for the 4x4 cross_bar.
- One instance sits in front of each slave port.
- Inputs: the address-decoded request vector from all masters (addr[31:30] == slave index, already decoded upstream) and the slave's _ack.
- Issues a one-hot grant, holds it for the full transaction until the slave acks, then rotates priority.
- Drives the crossbar's master->slave routing select and the slave->master _ack/_rdata return path.

Parameters:
- N_MASTERS, 4, number of requesting masters; must be ≥2.
- IDX_W, $clog2(N_MASTERS), width of the grant index.
- TIMEOUT_CYCLES, 16, max cycles in GRANT without ack before forced release; used only with CB_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous reset, active-high.
- req  input  N_MASTERS  per-master request already decoded for this slave; a master holds its bit until it sees its _ack.
- slave_ack  input  1  slave _ack for the current transaction.
- grant  output  N_MASTERS  one-hot grant, registered.
- grant_idx  output  IDX_W  binary index of the granted master; valid only while grant_valid.
- grant_valid  output  1  OR of grant; slave-side mux enable.
- timeout_err  output  1  one-cycle pulse on forced release; exists only with CB_ARB_TIMEOUT_EN.

Behaviour:
- Reset (rst=1 at a clk edge):
  - grant=0, grant_idx=0, grant_valid=0, timeout_err=0.
  - state=IDLE, priority pointer ptr=0 (master 0 highest), timeout counter=0.
  - Reset mid-GRANT drops grant on that same edge; the in-flight ack is lost.
- FSM states: IDLE and GRANT.
- IDLE:
  - If req≠0, winner = first set bit of req scanning ptr, ptr+1, … modulo N_MASTERS.
  - Next edge: grant=onehot(winner), grant_idx=winner, state=GRANT.
  - If req=0, stay in IDLE with outputs 0.
  - Latency is one cycle: req sampled at edge k gives grant visible after edge k.
- GRANT, hold:
  - grant is held stable.
  - req bits of other masters are ignored; they do not preempt.
- GRANT, completion: slave_ack=1 while grant_valid=1.
  - ptr <= winner+1, wrapping N_MASTERS-1 -> 0.
  - Re-arbitrate in the same cycle on req with the winner's bit masked, using the new ptr.
  - If any masked request exists, the next edge grants the new winner; back-to-back, no bubble, stay in GRANT.
  - Otherwise the next edge gives grant=0 and state=IDLE.
  - A master that just completed can win again only from IDLE: one bubble cycle minimum when it is the sole requester.
- GRANT, abort: req[winner]=0 with slave_ack=0.
  - Release on the next edge (grant=0, IDLE).
  - ptr <= winner+1.
- Simultaneous slave_ack=1 and req[winner]=0: treated as completion.
- slave_ack in IDLE is ignored; no state change, ptr unchanged.
- Invariants:
  - grant is always zero or one-hot.
  - grant_idx equals the index of the set bit while grant_valid.
  - grant never changes except at completion, abort, timeout or reset.
- Pointer wrap: winner=N_MASTERS-1 gives ptr=0.

Optional Feature:
- Macro: CB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT and increments each GRANT cycle without slave_ack.
  - When it reaches TIMEOUT_CYCLES-1 with no ack, the next edge forces release exactly as abort (grant=0, IDLE, ptr <= winner+1) and pulses timeout_err=1 for one cycle.
  - An ack in the final cycle wins over the timeout.
  - The counter resets to 0 on rst.
- Undefined:
  - No counter and no timeout_err port.
  - GRANT holds indefinitely until ack or abort.

Test Plan:
- Reset/idle: rst=1 for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0 throughout. Release rst -> grant=4'b0001 one cycle later (ptr=0).
- Two-master contention (masters 1 and 3 both targeting slave 3, addr[31:30]=2'b11, wdata=5): req=4'b1010 held, ack 3 cycles after grant -> grant=4'b0010 first. On ack, grant switches to 4'b1000 on the next edge with no bubble. After the second ack -> grant=0, ptr=0.
- Full rotation: req=4'b1111 held constantly, ack every 2nd grant cycle -> grant order 0001, 0010, 0100, 1000, 0001; grant_idx 0, 1, 2, 3, 0.
- Sole requester re-grant: req=4'b0100, ack -> grant=0 for exactly one cycle, then 4'b0100 again. slave_ack pulsed in IDLE -> no change.
- Abort and mid-reset: master 2 granted, drops req without ack -> grant=0 next edge, ptr=3. Separately, rst=1 while grant=4'b1000 -> grant=0 on that edge, ptr=0.
- Timeout (CB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16): master 0 granted, no ack for 16 cycles -> timeout_err=1 for one cycle, grant=0, ptr=1. An ack on cycle 16 instead -> normal completion, no timeout_err.
